jtpopeye_dma: RTL and testbench

- Transmitter end of the object DMA link: copies the CPU object RAM into the video object buffer.
- It raises ROHVS once per transfer and strobes ROHVCK once per byte; the video buffer receives on those strobes.
- It sits on the CPU board side. It takes the bus from the Z80 with a BUSRQ/BUSAK handshake during vertical blanking, once the CPU has armed a transfer.

---
 rtl/jtpopeye_dma.sv | 102 ++++++++++
 tb/tb_jtpopeye_dma.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_dma.sv
// Object DMA transmitter: takes the Z80 bus during vertical blanking and streams
// the object RAM to the video object buffer, one ROHVCK strobe per byte.
module jtpopeye_dma #(
  parameter int unsigned       AW     = 10,
  parameter logic [AW-1:0]     BASE   = '0,
  parameter int unsigned       NBYTES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_trig,
  input  logic          VB,
  input  logic          busak_n,
  output logic          busrq_n,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_dout,
  output logic          ROHVS,
  output logic          ROHVCK,
  output logic [7:0]    DMA_D,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    READ = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST = BASE + AW'(NBYTES - 1);

  state_t state;
  logic   pending;
  logic   vb_last;
  logic   vb_rise;

  assign vb_rise = VB & ~vb_last;

  // Bus handshake: busrq_n falls and stays low until DONE; the first cen with
  // busak_n low grants the bus. Later busak_n changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= 1'b0;
      vb_last  <= 1'b0;
      busrq_n  <= 1'b1;
      busy     <= 1'b0;
      ram_addr <= BASE;
      ROHVS    <= 1'b0;
      ROHVCK   <= 1'b0;
      DMA_D    <= 8'd0;
    end else begin
      // Arming is cen-independent so a one-clk CPU strobe is never lost
      if (dma_trig) pending <= 1'b1;
      if (cen) begin
        vb_last <= VB;
        case (state)
          IDLE: begin
            if (pending && vb_rise) begin
              state   <= REQ;
              busrq_n <= 1'b0;
              busy    <= 1'b1;
              if (!dma_trig) pending <= 1'b0;
            end
          end
          REQ: begin
            if (!busak_n) begin
              ram_addr <= BASE;
              ROHVS    <= 1'b1;
              state    <= READ;
            end
          end
          READ: begin
            ROHVS  <= 1'b0;
            ROHVCK <= 1'b0;
            state  <= SEND;
          end
          SEND: begin
            DMA_D  <= ram_dout;
            ROHVCK <= 1'b1;
            if (ram_addr == LAST) begin
              state <= DONE;
            end else begin
              ram_addr <= ram_addr + AW'(1);
              state    <= READ;
            end
          end
          DONE: begin
            ROHVCK   <= 1'b0;
            busrq_n  <= 1'b1;
            busy     <= 1'b0;
            ram_addr <= BASE;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Directed bench for jtpopeye_dma: a full 256-byte instance and a 4-byte
// wrapping instance running at quarter-rate cen.
module tb_jtpopeye_dma;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 0: defaults ----------------
  logic       cen0 = 1'b1, dma_trig0 = 1'b0, vb0 = 1'b0, busak0_n = 1'b1;
  logic       busrq0_n, rohvs0, rohvck0, busy0;
  logic [9:0] ram_addr0;
  logic [7:0] ram_dout0 = 8'd0, dma_d0, pat0 = 8'd0;

  jtpopeye_dma dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen0), .dma_trig(dma_trig0), .VB(vb0),
    .busak_n(busak0_n), .busrq_n(busrq0_n), .ram_addr(ram_addr0),
    .ram_dout(ram_dout0), .ROHVS(rohvs0), .ROHVCK(rohvck0), .DMA_D(dma_d0),
    .busy(busy0)
  );

  always @(posedge clk) if (cen0) ram_dout0 <= ram_addr0[7:0] ^ pat0;

  // ---------------- instance 1: BASE=3FE, NBYTES=4, cen/4 ----------------
  logic       cen1 = 1'b0, dma_trig1 = 1'b0, vb1 = 1'b0, busak1_n = 1'b1;
  logic       busrq1_n, rohvs1, rohvck1, busy1;
  logic [9:0] ram_addr1;
  logic [7:0] ram_dout1 = 8'd0, dma_d1;
  logic [1:0] cdiv = 2'd0;

  jtpopeye_dma #(.AW(10), .BASE(10'h3FE), .NBYTES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen1), .dma_trig(dma_trig1), .VB(vb1),
    .busak_n(busak1_n), .busrq_n(busrq1_n), .ram_addr(ram_addr1),
    .ram_dout(ram_dout1), .ROHVS(rohvs1), .ROHVCK(rohvck1), .DMA_D(dma_d1),
    .busy(busy1)
  );

  always @(negedge clk) begin
    cdiv <= cdiv + 2'd1;
    cen1 <= (cdiv == 2'd3);
  end
  always @(posedge clk) if (cen1) ram_dout1 <= ram_addr1[7:0] ^ 8'hA5;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  int   n_ck0 = 0, n_vs0 = 0, n_ck1 = 0, n_vs1 = 0, w1 = 0;
  logic rohvck0_q = 1'b0, rohvs0_q = 1'b0, rohvck1_q = 1'b0, rohvs1_q = 1'b0;

  always @(negedge clk) begin
    if (rohvck0 && !rohvck0_q) begin
      n_ck0++;
      check("dut0_sb_has_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("dut0_dma_d", 32'(dma_d0), 32'(exp_q.pop_front()));
    end
    if (rohvs0 && !rohvs0_q) n_vs0++;
    rohvck0_q = rohvck0;
    rohvs0_q  = rohvs0;

    if (rohvck1) w1++;
    if (rohvck1 && !rohvck1_q) begin
      n_ck1++;
      check("dut1_sb_has_expected", 32'(exp1_q.size() > 0), 32'd1);
      if (exp1_q.size() > 0) check("dut1_dma_d", 32'(dma_d1), 32'(exp1_q.pop_front()));
    end
    if (!rohvck1 && rohvck1_q) begin
      check("dut1_rohvck_clk_width", 32'(w1), 32'd4);
      w1 = 0;
    end
    if (rohvs1 && !rohvs1_q) n_vs1++;
    rohvck1_q = rohvck1;
    rohvs1_q  = rohvs1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trig0();
    dma_trig0 = 1'b1;
    tick(1);
    dma_trig0 = 1'b0;
    tick(1);
  endtask

  task automatic frame0();
    vb0 = 1'b1;
    tick(4);
    vb0 = 1'b0;
    tick(4);
  endtask

  task automatic push_frame0(input logic [7:0] pat);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ pat);
  endtask

  // Acknowledge after ack_delay cen, run to bus release, optionally pulsing
  // dma_trig at cen number trig_at after acknowledge.
  task automatic do_transfer0(input int ack_delay, input int trig_at);
    int vs_b, ck_b, n;
    vs_b = n_vs0;
    ck_b = n_ck0;
    tick(ack_delay);
    check("req_rohvs_low", 32'(rohvs0), 32'd0);
    check("req_addr_base", 32'(ram_addr0), 32'h000);
    check("req_busrq_low", 32'(busrq0_n), 32'd0);
    check("req_busy_high", 32'(busy0), 32'd1);
    check("req_no_rohvs_yet", 32'(n_vs0 - vs_b), 32'd0);
    busak0_n = 1'b0;
    n = 0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      n++;
      dma_trig0 = (n == trig_at);
      if (busrq0_n) break;
    end
    dma_trig0 = 1'b0;
    busak0_n  = 1'b1;
    check("ack_to_release_cen", 32'(n), 32'd514);
    tick(2);
    check("rohvs_pulses", 32'(n_vs0 - vs_b), 32'd1);
    check("rohvck_pulses", 32'(n_ck0 - ck_b), 32'd256);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("busy_released", 32'(busy0), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ck_b, vs_b, n;

    // Reset values
    tick(3);
    check("rst_busrq_n", 32'(busrq0_n), 32'd1);
    check("rst_rohvs", 32'(rohvs0), 32'd0);
    check("rst_rohvck", 32'(rohvck0), 32'd0);
    check("rst_dma_d", 32'(dma_d0), 32'd0);
    check("rst_ram_addr", 32'(ram_addr0), 32'h000);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_dut1_ram_addr", 32'(ram_addr1), 32'h3FE);
    rst_n = 1'b1;
    tick(2);

    // No trigger: three frames, nothing happens
    repeat (3) frame0();
    check("notrig_busrq_n", 32'(busrq0_n), 32'd1);
    check("notrig_busy", 32'(busy0), 32'd0);
    check("notrig_rohvck", 32'(n_ck0), 32'd0);
    check("notrig_rohvs", 32'(n_vs0), 32'd0);

    // Five triggers collapse into one transfer; re-arm during it
    repeat (5) pulse_trig0();
    pat0 = 8'h00;
    push_frame0(pat0);
    vb0 = 1'b1;
    tick(1);
    check("vb_rise_busrq_low", 32'(busrq0_n), 32'd0);
    vb0 = 1'b0;
    do_transfer0(2, 100);
    tick(10);
    check("rearm_waits_for_vb", 32'(busrq0_n), 32'd1);

    // Second transfer on next VB rise
    pat0 = 8'h5A;
    push_frame0(pat0);
    vb0 = 1'b1;
    tick(1);
    check("second_vb_busrq_low", 32'(busrq0_n), 32'd0);
    do_transfer0(2, 0);
    vb0 = 1'b0;
    tick(4);
    frame0();
    check("single_rearm_only", 32'(busrq0_n), 32'd1);

    // Delayed acknowledge
    pulse_trig0();
    pat0 = 8'hC3;
    push_frame0(pat0);
    vb0 = 1'b1;
    tick(1);
    vb0 = 1'b0;
    do_transfer0(100, 0);

    // Async reset at byte 37, with a pending re-arm that reset must clear
    pulse_trig0();
    pat0 = 8'h11;
    push_frame0(pat0);
    vb0 = 1'b1;
    tick(1);
    vb0 = 1'b0;
    pulse_trig0();
    busak0_n = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (rohvck0 && dma_d0 == (8'd36 ^ pat0)) break;
    end
    check("byte37_reached", 32'(rohvck0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busrq_n", 32'(busrq0_n), 32'd1);
    check("arst_rohvck", 32'(rohvck0), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_ram_addr", 32'(ram_addr0), 32'h000);
    check("arst_dma_d", 32'(dma_d0), 32'd0);
    exp_q.delete();
    busak0_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    ck_b = n_ck0;
    vs_b = n_vs0;
    repeat (3) frame0();
    check("post_rst_busrq_n", 32'(busrq0_n), 32'd1);
    check("post_rst_rohvck", 32'(n_ck0 - ck_b), 32'd0);
    check("post_rst_rohvs", 32'(n_vs0 - vs_b), 32'd0);

    // Quarter-rate cen, 4 bytes wrapping through 3FE,3FF,000,001
    exp1_q.push_back(8'hFE ^ 8'hA5);
    exp1_q.push_back(8'hFF ^ 8'hA5);
    exp1_q.push_back(8'h00 ^ 8'hA5);
    exp1_q.push_back(8'h01 ^ 8'hA5);
    dma_trig1 = 1'b1;
    tick(1);
    dma_trig1 = 1'b0;
    vb1 = 1'b1;
    for (int k = 0; k < 40 && busrq1_n; k++) tick(1);
    check("dut1_busrq_low", 32'(busrq1_n), 32'd0);
    tick(8);
    check("dut1_req_addr_base", 32'(ram_addr1), 32'h3FE);
    busak1_n = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (cen1) n++;
      #1;
      if (busrq1_n) break;
    end
    busak1_n = 1'b1;
    vb1 = 1'b0;
    check("dut1_ack_to_release_cen", 32'(n), 32'd10);
    tick(6);
    check("dut1_rohvck_pulses", 32'(n_ck1), 32'd4);
    check("dut1_rohvs_pulses", 32'(n_vs1), 32'd1);
    check("dut1_sb_drained", 32'(exp1_q.size()), 32'd0);
    check("dut1_addr_back_to_base", 32'(ram_addr1), 32'h3FE);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
